proc_mem_loader: RTL and testbench

- Unified 16-bit instruction/data memory that sits directly downstream of the multicycle ALU core's memory port. It supplies fetched instructions and operands, and it absorbs result writes.
- Includes a valid/ready program-loader port. The loader fills memory after reset while the block holds the core in reset through o_cpuRst. The core is released only once loading completes.
- Read latency is one cycle: the address presented in cycle N produces data on o_cpuData in cycle N+1, which matches the core's FETCH/DECODE/EXECUTE timing.

---
 rtl/proc_mem_loader.sv | 151 +++++++++++++++
 tb/tb_proc_mem_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/proc_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : proc_mem_loader
// Description : Unified 16-bit instruction/data memory for the multicycle ALU
//               core, with a valid/ready program loader that holds the core in
//               reset until loading completes. Optional write protection of
//               the loaded program region via PROC_MEM_WR_PROTECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_mem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ldValid,
    input  logic [DATA_W-1:0] i_ldData,
    input  logic              i_ldLast,
    output logic              o_ldReady,
    input  logic [15:0]       i_cpuAddr,
    input  logic [DATA_W-1:0] i_cpuData,
    input  logic              i_cpuWrEn,
    output logic [DATA_W-1:0] o_cpuData,
    output logic              o_cpuRst,
    output logic              o_loadDone,
    output logic [ADDR_W:0]   o_progLen,
    output logic [15:0]       o_wrCount,
    output logic              o_addrErr,
    output logic              o_wrProtErr
);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t              r_state;
    state_t              w_stateNxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [ADDR_W:0]     r_progLen;
    logic [DATA_W-1:0]   r_cpuData;
    logic [15:0]         r_wrCount;
    logic                r_addrErr;

    logic                w_ldAccept;
    logic [ADDR_W-1:0]   w_ldPtr;
    logic [ADDR_W-1:0]   w_cpuIdx;
    logic                w_inRange;
    logic                w_run;
    logic                w_cpuWrReq;
    logic                w_protHit;
    logic                w_cpuWr;

    // The load pointer is the low bits of the program length counter.
    assign w_ldPtr    = r_progLen[ADDR_W-1:0];
    assign w_cpuIdx   = i_cpuAddr[ADDR_W-1:0];
    assign w_inRange  = (i_cpuAddr[15:ADDR_W] == '0);
    assign w_run      = (r_state == ST_RUN);
    assign w_ldAccept = i_ldValid && o_ldReady;
    assign w_cpuWrReq = w_run && !i_rst && i_cpuWrEn && w_inRange;
    assign w_cpuWr    = w_cpuWrReq && !w_protHit;

`ifdef PROC_MEM_WR_PROTECT_EN
    logic r_wrProtErr;

    assign w_protHit   = ({1'b0, w_cpuIdx} < r_progLen);
    assign o_wrProtErr = r_wrProtErr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrProtErr <= 1'b0;
        end else if (w_cpuWrReq && w_protHit) begin
            r_wrProtErr <= 1'b1;
        end
    end
`else
    assign w_protHit   = 1'b0;
    assign o_wrProtErr = 1'b0;
`endif

    always_comb begin
        w_stateNxt = r_state;
        o_ldReady  = 1'b0;
        o_cpuRst   = 1'b1;
        o_loadDone = 1'b0;
        case (r_state)
            ST_LOAD: begin
                o_ldReady = !i_rst;
                if (w_ldAccept && (i_ldLast || (w_ldPtr == c_LAST_IDX))) begin
                    w_stateNxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_stateNxt = ST_RUN;
            end
            ST_RUN: begin
                o_cpuRst   = 1'b0;
                o_loadDone = 1'b1;
            end
            default: begin
                w_stateNxt = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_LOAD;
            r_progLen <= '0;
            r_cpuData <= '0;
            r_wrCount <= '0;
            r_addrErr <= 1'b0;
        end else begin
            r_state <= w_stateNxt;
            if (w_ldAccept) begin
                r_progLen <= r_progLen + 1'b1;
            end
            case (r_state)
                ST_RELEASE: r_cpuData <= r_mem[w_cpuIdx];
                ST_RUN:     r_cpuData <= w_inRange ? r_mem[w_cpuIdx] : '0;
                default:    r_cpuData <= '0;
            endcase
            if (w_cpuWr && (r_wrCount != 16'hFFFF)) begin
                r_wrCount <= r_wrCount + 16'd1;
            end
            if (w_run && !w_inRange) begin
                r_addrErr <= 1'b1;
            end
        end
    end

    // Array has no reset; read-first behaviour falls out of the registered read.
    always_ff @(posedge i_clk) begin
        if (w_ldAccept) begin
            r_mem[w_ldPtr] <= i_ldData;
        end else if (w_cpuWr) begin
            r_mem[w_cpuIdx] <= i_cpuData;
        end
    end

    assign o_cpuData = r_cpuData;
    assign o_progLen = r_progLen;
    assign o_wrCount = r_wrCount;
    assign o_addrErr = r_addrErr;

endmodule
`default_nettype wire

// File: tb/tb_proc_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_mem_loader
// Description : Directed self-checking bench for proc_mem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_wr_en;
    logic [15:0] cpu_rdata;
    logic        cpu_rst;
    logic        load_done;
    logic [6:0]  prog_len;
    logic [15:0] wr_count;
    logic        addr_err;
    logic        wr_prot_err;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_wc  = 0;

    always #5 clk = ~clk;

    proc_mem_loader dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ldValid   (ld_valid),
        .i_ldData    (ld_data),
        .i_ldLast    (ld_last),
        .o_ldReady   (ld_ready),
        .i_cpuAddr   (cpu_addr),
        .i_cpuData   (cpu_wdata),
        .i_cpuWrEn   (cpu_wr_en),
        .o_cpuData   (cpu_rdata),
        .o_cpuRst    (cpu_rst),
        .o_loadDone  (load_done),
        .o_progLen   (prog_len),
        .o_wrCount   (wr_count),
        .o_addrErr   (addr_err),
        .o_wrProtErr (wr_prot_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; cpu_wr_en = 1'b0;
        step(); step();
        check("rst_ldReady",  ld_ready, 0);
        check("rst_cpuRst",   cpu_rst, 1);
        check("rst_loadDone", load_done, 0);
        check("rst_progLen",  prog_len, 0);
        check("rst_cpuData",  cpu_rdata, 0);
        check("rst_wrCount",  wr_count, 0);
        check("rst_addrErr",  addr_err, 0);
        check("rst_wrProt",   wr_prot_err, 0);

        rst = 1'b0;
        #1;
        check("load_ldReady", ld_ready, 1);

        // Three-word program with a 5-cycle valid gap after the first word
        ld_valid = 1'b1; ld_data = 16'h8042;
        step();
        check("load_len1", prog_len, 1);
        ld_valid = 1'b0; ld_data = 16'hDEAD;
        repeat (5) step();
        check("gap_len", prog_len, 1);
        check("gap_cpuRst", cpu_rst, 1);
        ld_valid = 1'b1; ld_data = 16'h0000;
        step();
        ld_data = 16'h0005; ld_last = 1'b1;
        step();
        ld_valid = 1'b0; ld_last = 1'b0;
        check("load_len3", prog_len, 3);
        check("release_cpuRst", cpu_rst, 1);
        check("release_ldReady", ld_ready, 0);
        check("release_loadDone", load_done, 0);
        step();
        check("run_cpuRst", cpu_rst, 0);
        check("run_loadDone", load_done, 1);
        check("run_first_data", cpu_rdata, 16'h8042);
        cpu_addr = 16'd1;
        step();
        check("rd_addr1", cpu_rdata, 16'h0000);
        cpu_addr = 16'd2;
        step();
        check("rd_addr2", cpu_rdata, 16'h0005);

        // Write, read-during-write, read-back
        cpu_addr = 16'd10; cpu_wdata = 16'h1111; cpu_wr_en = 1'b1;
        step();
        exp_wc = 1;
        check("wc_after_1111", wr_count, exp_wc);
        cpu_wdata = 16'hBEEF;
        step();
        exp_wc = 2;
        check("rdw_old", cpu_rdata, 16'h1111);
        check("wc_after_beef", wr_count, exp_wc);
        cpu_wr_en = 1'b0;
        step();
        check("rd_beef", cpu_rdata, 16'hBEEF);

        // Write into the loaded program region
        cpu_addr = 16'd1; cpu_wdata = 16'hAAAA; cpu_wr_en = 1'b1;
        step();
        cpu_wr_en = 1'b0;
        step();
`ifdef PROC_MEM_WR_PROTECT_EN
        check("prot_data", cpu_rdata, 16'h0000);
        check("prot_flag", wr_prot_err, 1);
`else
        exp_wc = 3;
        check("noprot_data", cpu_rdata, 16'hAAAA);
        check("noprot_flag", wr_prot_err, 0);
`endif
        check("prot_wc", wr_count, exp_wc);

        cpu_addr = 16'd3; cpu_wdata = 16'h3333; cpu_wr_en = 1'b1;
        step();
        cpu_wr_en = 1'b0;
        step();
        exp_wc = exp_wc + 1;
        check("wr_addr3", cpu_rdata, 16'h3333);
        check("wc_addr3", wr_count, exp_wc);

        // Out-of-range access aliasing onto index 0
        cpu_addr = 16'h0040; cpu_wdata = 16'h5555; cpu_wr_en = 1'b1;
        step();
        cpu_wr_en = 1'b0;
        check("oob_rd_zero", cpu_rdata, 0);
        check("oob_flag", addr_err, 1);
        check("oob_wc", wr_count, exp_wc);
        cpu_addr = 16'd0;
        step();
        check("oob_mem0", cpu_rdata, 16'h8042);
        check("oob_sticky", addr_err, 1);

        // Reset mid-RUN with a loader word offered at the same time
        rst = 1'b1; ld_valid = 1'b1; ld_data = 16'hDEAD;
        step();
        check("rr_cpuRst", cpu_rst, 1);
        check("rr_loadDone", load_done, 0);
        check("rr_addrErr", addr_err, 0);
        check("rr_wrProt", wr_prot_err, 0);
        check("rr_wrCount", wr_count, 0);
        check("rr_progLen", prog_len, 0);
        check("rr_cpuData", cpu_rdata, 0);
        rst = 1'b0; ld_valid = 1'b0;
        #1;
        check("rr_ldReady", ld_ready, 1);

        // Full 64-word load without ld_last
        ld_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            ld_data = 16'h1000 + 16'(i);
            step();
        end
        ld_valid = 1'b0;
        check("full_len", prog_len, 64);
        check("full_ldReady", ld_ready, 0);
        check("full_cpuRst", cpu_rst, 1);
        step();
        check("full_run", cpu_rst, 0);
        check("full_mem0", cpu_rdata, 16'h1000);
        check("full_len_hold", prog_len, 64);
        cpu_addr = 16'd63;
        step();
        check("full_mem63", cpu_rdata, 16'h103F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
